seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Parametrised, iterative shift-add multiplier; next generation of the team's combinational 8-bit array multiplier.
- Trades area for latency: one partial product is accumulated per clock.
- Adds a per-operation signed/unsigned mode and a start/busy/done handshake.
- Sits in the datapath next to the ALU and serves any client that can wait WIDTH+1 cycles for a result.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32. Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset. Clears all state immediately.
- start  input  1  request pulse; sampled only in IDLE.
- is_signed  input  1  1 = operands and product are two's complement; 0 = unsigned. Sampled with start.
- top  input  WIDTH  multiplicand. Sampled with start.
- bottom  input  WIDTH  multiplier. Sampled with start.
- busy  output  1  high from the cycle after start is accepted through the done cycle inclusive.
- done  output  1  single-cycle pulse; product is valid in this cycle.
- product  output  2*WIDTH  result register. Holds its value until the next completion or reset.

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, product=0, accumulator/count/operand registers=0.
- States:
  - IDLE: start=1 -> RUN. Registers written: mcand=|top| (if is_signed, else top), mplier=|bottom| (if is_signed, else bottom), neg = is_signed & (top[MSB] ^ bottom[MSB]), acc=0, count=0.
  - RUN: each cycle, if mplier[0]=1 then acc += mcand << count. Then mplier >>= 1 and count++. When count==WIDTH-1, the edge writes product = neg ? -(acc_next) : acc_next and goes to DONE.
  - DONE: done=1 for exactly one cycle, then -> IDLE.
- Timing:
  - Start accepted on edge T; RUN occupies cycles T+1..T+WIDTH; DONE is cycle T+WIDTH+1.
  - Latency from start to done is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
  - busy=1 in RUN and DONE; busy=0 in IDLE.
- Width rules:
  - |x| is computed in WIDTH+1 bits, so the most negative signed value (e.g. -128 at WIDTH=8) gives a magnitude of 2^(WIDTH-1) with no overflow.
  - acc is 2*WIDTH bits. Unsigned max (2^W-1)^2 and signed max (-2^(W-1))^2 both fit, so there is no overflow in either mode.
  - Final negation is two's complement over 2*WIDTH bits. A zero result with neg=1 yields 0.
- Boundary and corner cases:
  - start while busy=1: ignored, with no effect on the operation in flight or on product.
  - start in the same cycle as done: ignored (FSM is in DONE). A client must reassert start in the next cycle.
  - Operand/mode changes while busy: no effect, because all inputs are sampled only at acceptance.
  - Zero operand: still takes the full WIDTH+1 latency (fixed latency, no early exit).
  - Reset mid-operation: the operation is abandoned, no done pulse, product=0.
- No combinational path from inputs to outputs; busy, done and product are all registered.

Decomposition:
- Package mult_pkg:
  - state enum {IDLE, RUN, DONE}, 2-bit encoding.
  - Count-width constant function clog2(WIDTH).
  - Localparam PW=2*WIDTH supplied via a function taking WIDTH.
- One natural combinational sub-module: twos_abs. Parameter N. Inputs: x[N], en. Output: mag[N+1] = (en & x[N-1]) ? -x : x.
  - Used twice at load.
  - The final negation is done inline.
- FSM, datapath and handshake live in seq_multiplier.

Test Plan:
- WIDTH=8, unsigned 255*255 -> product=0xFE01, done exactly 9 cycles after the start edge, busy high for 9 cycles.
- WIDTH=8, is_signed=1, top=0x80, bottom=0x80 (-128*-128) -> product=0x4000. Same operands with is_signed=0 -> 0x4000 (128*128).
- WIDTH=8, is_signed=1, top=0xFD, bottom=0x05 (-3*5) -> product=0xFFF1. Same operands with is_signed=0 (253*5) -> 0x04F1.
- WIDTH=8: start 7*6, then pulse start with 9*9 on cycles T+3 and T+9 (DONE cycle) -> product=42 (0x002A), single done pulse, second request not executed.
- WIDTH=8: start 200*3, assert reset on cycle T+4 -> busy=0, done=0, product=0 immediately. A new start 12*11 after release -> 132 (0x0084) with normal latency.
- WIDTH=4 instance: unsigned 15*15 -> 225 (0xE1) after 5 cycles; signed 0x8*0x7 (-8*7) -> 0xC8 (-56).

Source files
------------

// File: rtl/seq_multiplier_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int w);
        int r;
        r = 0;
        while ((1 << r) < w) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int pw(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/response bundle between a multiply client and seq_multiplier.
interface seq_multiplier_if #(
    parameter int WIDTH = 8
) ();

    logic                 start;
    logic                 is_signed;
    logic [WIDTH-1:0]     top;
    logic [WIDTH-1:0]     bottom;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, is_signed, top, bottom,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, top, bottom,
        output busy, done, product
    );

endinterface

// File: rtl/seq_multiplier_twos_abs.sv
// Optional two's-complement magnitude, widened by one bit so -2^(N-1) fits.
module twos_abs #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic         en,
    output logic [N:0]   mag
);

    logic [N:0] w_ext;

    assign w_ext = {x[N-1], x};
    assign mag   = (en && x[N-1]) ? (~w_ext + 1'b1) : {1'b0, x};

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per clock, fixed
// WIDTH+1 cycle latency, signed or unsigned per operation.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    seq_multiplier_if.slave   bus
);

    localparam int PW = pw(WIDTH);
    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          r_state;
    logic [WIDTH:0]  r_mcand;
    logic [WIDTH:0]  r_mplier;
    logic            r_neg;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_count;
    logic            r_busy;
    logic            r_done;
    logic [PW-1:0]   r_product;

    logic [WIDTH:0]  w_amag;
    logic [WIDTH:0]  w_bmag;
    logic [PW-1:0]   w_pp;
    logic [PW-1:0]   w_acc_next;
    logic [PW-1:0]   w_res;

    twos_abs #(.N(WIDTH)) u_abs_top (
        .x   (bus.top),
        .en  (bus.is_signed),
        .mag (w_amag)
    );

    twos_abs #(.N(WIDTH)) u_abs_bot (
        .x   (bus.bottom),
        .en  (bus.is_signed),
        .mag (w_bmag)
    );

    assign w_pp = r_mplier[0]
                ? ({{(PW-WIDTH-1){1'b0}}, r_mcand} << r_count)
                : '0;
    assign w_acc_next = r_acc + w_pp;
    // Sign is reapplied only once, on the final accumulator value.
    assign w_res = r_neg ? (~w_acc_next + 1'b1) : w_acc_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_neg     <= 1'b0;
            r_acc     <= '0;
            r_count   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_mcand  <= w_amag;
                        r_mplier <= w_bmag;
                        r_neg    <= bus.is_signed &
                                    (bus.top[WIDTH-1] ^ bus.bottom[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + CW'(1);
                    if (r_count == LAST) begin
                        r_product <= w_res;
                        r_done    <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier at WIDTH=8 and WIDTH=4.
module tb_seq_multiplier;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    seq_multiplier_if #(.WIDTH(8)) m8 ();
    seq_multiplier_if #(.WIDTH(4)) m4 ();

    seq_multiplier #(.WIDTH(8)) u8 (
        .clk   (clk),
        .reset (reset),
        .bus   (m8)
    );

    seq_multiplier #(.WIDTH(4)) u4 (
        .clk   (clk),
        .reset (reset),
        .bus   (m4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input int w, input bit s,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint av, bv, p;
        longint mask;
        mask = (longint'(1) << w) - 1;
        av = longint'(a) & mask;
        bv = longint'(b) & mask;
        if (s && av[w-1]) av = av - (longint'(1) << w);
        if (s && bv[w-1]) bv = bv - (longint'(1) << w);
        p = av * bv;
        return p & ((longint'(1) << (2 * w)) - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int w, input bit st, input bit s,
                       input logic [7:0] a, input logic [7:0] b);
        if (w == 8) begin
            m8.start = st; m8.is_signed = s; m8.top = a; m8.bottom = b;
        end else begin
            m4.start = st; m4.is_signed = s;
            m4.top = a[3:0]; m4.bottom = b[3:0];
        end
    endtask

    function automatic logic get_done(input int w);
        return (w == 8) ? m8.done : m4.done;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 8) ? m8.busy : m4.busy;
    endfunction

    function automatic logic [15:0] get_prod(input int w);
        return (w == 8) ? m8.product : {8'h00, m4.product};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation: start cycle, then watch until done (bounded).
    task automatic run(input int w, input bit s, input logic [7:0] a,
                       input logic [7:0] b, input string tag);
        int cyc, nb;
        logic [15:0] exp;
        logic [63:0] m;
        m = model(w, s, {24'h0, a}, {24'h0, b});
        exp = m[15:0];
        drv(w, 1'b1, s, a, b);
        step();
        drv(w, 1'b0, ~s, 8'($urandom), 8'($urandom));
        cyc = 1;
        nb  = 0;
        while (!get_done(w) && cyc < 40) begin
            if (get_busy(w)) nb++;
            step();
            cyc++;
        end
        if (get_busy(w)) nb++;
        chk({tag, " latency"}, cyc, w + 1);
        chk({tag, " busy_cycles"}, nb, w + 1);
        chk({tag, " product"}, get_prod(w), exp);
        step();
        chk({tag, " done_clear"}, get_done(w), 0);
        chk({tag, " busy_clear"}, get_busy(w), 0);
        chk({tag, " hold"}, get_prod(w), exp);
    endtask

    initial begin
        int nd, cyc;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        drv(8, 1'b0, 1'b0, 8'h00, 8'h00);
        drv(4, 1'b0, 1'b0, 8'h00, 8'h00);
        #2;
        chk("rst busy", m8.busy, 0);
        chk("rst done", m8.done, 0);
        chk("rst product", m8.product, 0);
        step();
        step();
        reset = 1'b0;
        step();

        run(8, 1'b0, 8'hFF, 8'hFF, "u255x255");
        run(8, 1'b1, 8'h80, 8'h80, "s_m128sq");
        run(8, 1'b0, 8'h80, 8'h80, "u128sq");
        run(8, 1'b1, 8'hFD, 8'h05, "s_m3x5");
        run(8, 1'b0, 8'hFD, 8'h05, "u253x5");
        run(8, 1'b1, 8'h00, 8'h9C, "s_zero");
        run(8, 1'b0, 8'h00, 8'h00, "u_zero");

        // Requests while busy and on the done cycle must be ignored.
        drv(8, 1'b1, 1'b0, 8'd7, 8'd6);
        step();
        drv(8, 1'b0, 1'b0, 8'd0, 8'd0);
        step();
        step();
        drv(8, 1'b1, 1'b0, 8'd9, 8'd9);
        step();
        drv(8, 1'b0, 1'b0, 8'd0, 8'd0);
        cyc = 4;
        while (!m8.done && cyc < 40) begin
            step();
            cyc++;
        end
        chk("busy_start latency", cyc, 9);
        chk("busy_start product", m8.product, 16'h002A);
        drv(8, 1'b1, 1'b0, 8'd9, 8'd9);
        step();
        drv(8, 1'b0, 1'b0, 8'd0, 8'd0);
        chk("done_start busy", m8.busy, 0);
        chk("done_start done", m8.done, 0);
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (m8.done || m8.busy) nd++;
            step();
        end
        chk("done_start no_rerun", nd, 0);
        chk("done_start hold", m8.product, 16'h002A);

        // Asynchronous reset mid-operation.
        drv(8, 1'b1, 1'b0, 8'd200, 8'd3);
        step();
        drv(8, 1'b0, 1'b0, 8'd0, 8'd0);
        step();
        step();
        step();
        reset = 1'b1;
        #1;
        chk("midrst busy", m8.busy, 0);
        chk("midrst done", m8.done, 0);
        chk("midrst product", m8.product, 0);
        step();
        reset = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (m8.done) nd++;
            step();
        end
        chk("midrst no_done", nd, 0);
        run(8, 1'b0, 8'd12, 8'd11, "after_rst");

        run(4, 1'b0, 8'h0F, 8'h0F, "w4 u15x15");
        run(4, 1'b1, 8'h08, 8'h07, "w4 s_m8x7");

        for (int i = 0; i < 12; i++) begin
            run(8, 1'($urandom), 8'($urandom), 8'($urandom), "rand8");
        end
        for (int i = 0; i < 8; i++) begin
            run(4, 1'($urandom), 8'($urandom), 8'($urandom), "rand4");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
